commit_buffer: RTL and testbench
================================

Name: commit_buffer

Overview:
Parametrised commit stage with a DEPTH-entry in-order queue between the memory stage and the register file / CSR write ports.
- Absorbs bursts from the memory stage while writeback is stalled (wb_ready_i low).
- Retires at most one instruction per cycle.
- Exposes a pending-write scoreboard for decode hazard checks.
- Supports a pipeline flush and counts retired instructions.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
XLEN, 32, data/pc/inst/CSR address and data width
REG_AW, 5, GPR address width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
valid_pre_i  in  1  upstream entry valid
ready_pre_o  out  1  buffer can accept an entry
pc_i  in  XLEN  instruction pc
inst_i  in  XLEN  instruction word
wsel_i  in  1  1 = write mem_result_i, 0 = write alu_result_i
wena_i  in  1  GPR write enable
waddr_i  in  REG_AW  GPR destination
alu_result_i  in  XLEN  ALU result
mem_result_i  in  XLEN  load result
csr_wena_i  in  1  CSR write enable
csr_waddr_i  in  XLEN  CSR address
csr_wdata_i  in  XLEN  CSR data
wb_ready_i  in  1  writeback can accept a retire this cycle
flush_i  in  1  discard all queued entries
rs1_i, rs2_i  in  REG_AW  decode source registers
rs1_pending_o, rs2_pending_o  out  1  a queued entry will write that register
commit_valid_o  out  1  head entry retires this cycle
commit_pc_o  out  XLEN  head pc (difftest)
commit_inst_o  out  XLEN  head inst (difftest)
wena_o  out  1  GPR write strobe
waddr_o  out  REG_AW  GPR address
wdata_o  out  XLEN  GPR data
csr_wena_o  out  1  CSR write strobe
csr_waddr_o  out  XLEN  CSR address
csr_wdata_o  out  XLEN  CSR data
instret_o  out  64  retired instruction count
count_o  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (reset low, asynchronous):
  - head, tail and count cleared; all entry valid bits cleared; instret cleared.
  - All strobes, data outputs and pending outputs are 0.
  - ready_pre_o is 1.
- Enqueue:
  - ready_pre_o = (count != DEPTH) && !flush_i.
  - An enqueue happens on valid_pre_i && ready_pre_o.
  - Write data is resolved at enqueue (wsel_i mux). The entry stores pc, inst, wena, waddr, wdata and the CSR triple.
- Latency:
  - An entry enqueued at edge N is the head and visible on the outputs in cycle N+1.
  - There is no combinational pass-through from the upstream inputs to the outputs.
- Retire:
  - Retire happens when count != 0 && wb_ready_i && !flush_i.
  - commit_valid_o = retire.
  - wena_o = retire && head.wena && head.waddr != 0.
  - csr_wena_o = retire && head.csr_wena.
  - Data outputs show the head entry when count != 0, else 0.
- Simultaneous enqueue and retire:
  - count unchanged; head and tail both advance.
  - When full, ready_pre_o stays 0 even if a retire occurs in the same cycle. Full-and-retire gives no same-cycle acceptance.
- Wrap-around: head and tail are log2(DEPTH)-bit pointers wrapping modulo DEPTH. count disambiguates full from empty.
- Flush:
  - At the next edge, count, head and tail return to 0 and all valid bits clear.
  - No retire or enqueue occurs in the flush cycle; commit_valid_o and all strobes are 0.
  - instret is not affected.
  - Flush with an empty buffer is a no-op.
- Scoreboard:
  - rsX_pending_o = rsX_i != 0 && some valid entry has wena && waddr == rsX_i.
  - The head entry that retires this cycle still counts as pending in that cycle.
- instret: increments by 1 on each retire; wraps at 2^64.
- Strobe width: wena_o, csr_wena_o and commit_valid_o are single-cycle per retired entry.

Decomposition:
- Shared defines file holds:
  - Entry field widths and the entry bit layout (pc, inst, wena, waddr, wdata, csr_wena, csr_waddr, csr_wdata).
  - The localparam for the pointer width, log2(DEPTH).
- One natural sub-module: commit_buffer_fifo. It holds the storage array, head/tail/count and valid bits, with push/pop/flush inputs, and exposes the head entry plus a per-entry valid/waddr/wena vector for the scoreboard.
- The top level holds the write-data mux, retire gating, scoreboard compare and instret counter.

Test Plan:
1. Single pass:
   - Stimulus: after reset, enqueue pc=0x80000000, wena=1, waddr=5, wsel=0, alu=0x1234, with wb_ready_i=1.
   - Response: next cycle commit_valid_o=1, wena_o=1, waddr_o=5, wdata_o=0x1234; instret_o becomes 1.
2. Fill and stall:
   - Stimulus: wb_ready_i=0, push 4 entries with DEPTH=4.
   - Response: count_o=4, ready_pre_o=0, no strobes. Release wb_ready_i and observe 4 retires in order on consecutive cycles.
3. Wrap with concurrent traffic:
   - Stimulus: stream 10 entries with wb_ready_i toggling 1,0,1,...
   - Response: all retire in pc order, none dropped; instret_o=10; pointers pass index 3 -> 0.
4. Flush:
   - Stimulus: 3 entries queued, assert flush_i for one cycle.
   - Response: no strobes that cycle, count_o=0 next cycle, instret_o unchanged.
5. Scoreboard and x0:
   - Stimulus: queue entries writing x7 and x0, with rs1_i=7, rs2_i=0.
   - Response: rs1_pending_o=1, rs2_pending_o=0. The x0 entry retires with commit_valid_o=1 and wena_o=0.
6. Reset mid-operation:
   - Stimulus: assert reset low asynchronously with 2 entries queued.
   - Response: outputs drop to 0 and count_o=0 immediately, without waiting for a clock edge; ready_pre_o=1.

Source files
------------

// File: rtl/commit_buffer_pkg.sv
// Shared definitions for the commit buffer.
// Holds the default sizes, the pointer-width helper and the bit layout of one
// queued entry. An entry is a flat vector, LSB first:
//   csr_wdata | csr_waddr | csr_wena | wdata | waddr | wena | inst | pc
// so pc occupies the most significant XLEN bits.
package commit_buffer_pkg;

    localparam int CB_DEPTH  = 4;
    localparam int CB_XLEN   = 32;
    localparam int CB_REG_AW = 5;

    // Head/tail pointer width for the default depth.
    localparam int CB_PTR_W = $clog2(CB_DEPTH);

    // Pointer width for an arbitrary power-of-two depth (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int off_csr_wdata(input int xlen);
        return 0;
    endfunction

    function automatic int off_csr_waddr(input int xlen);
        return xlen;
    endfunction

    function automatic int off_csr_wena(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int off_wdata(input int xlen);
        return 2 * xlen + 1;
    endfunction

    function automatic int off_waddr(input int xlen);
        return 3 * xlen + 1;
    endfunction

    function automatic int off_wena(input int xlen, input int aw);
        return 3 * xlen + 1 + aw;
    endfunction

    function automatic int off_inst(input int xlen, input int aw);
        return 3 * xlen + 2 + aw;
    endfunction

    function automatic int off_pc(input int xlen, input int aw);
        return 4 * xlen + 2 + aw;
    endfunction

    function automatic int entry_w(input int xlen, input int aw);
        return 5 * xlen + 2 + aw;
    endfunction

endpackage

// File: rtl/commit_buffer_fifo.sv
// In-order entry storage for the commit buffer.
// Ports:
//   clock, reset        clock and asynchronous active-low reset
//   push, pop, flush    write tail / release head / discard everything
//   push_entry          packed entry written at the tail on push
//   head_entry          packed head entry, all zero while empty
//   count               occupancy (0..DEPTH)
//   entry_valid/wena/waddr  per-slot view used by the hazard scoreboard
// push and pop are never issued together with flush by the top level; flush
// still takes priority here so the storage stays self-consistent.
module commit_buffer_fifo
    import commit_buffer_pkg::*;
#(
    parameter  int DEPTH  = CB_DEPTH,
    parameter  int XLEN   = CB_XLEN,
    parameter  int REG_AW = CB_REG_AW,
    localparam int EW     = entry_w(XLEN, REG_AW),
    localparam int PW     = ptr_w(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [EW-1:0]                push_entry,
    output logic [EW-1:0]                head_entry,
    output logic [CW-1:0]                count,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0]             entry_wena,
    output logic [DEPTH-1:0][REG_AW-1:0] entry_waddr
);

    localparam int OFF_WENA  = off_wena(XLEN, REG_AW);
    localparam int OFF_WADDR = off_waddr(XLEN);

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [DEPTH-1:0] valid;

    // Pointers wrap modulo DEPTH by natural overflow; count tells full from empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                tail        <= tail + PW'(1);
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + PW'(1);
                valid[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: valid bits and count gate every use.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[tail] <= push_entry;
        end
    end

    assign head_entry  = (count != '0) ? mem[head] : '0;
    assign entry_valid = valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign entry_wena[i]  = mem[i][OFF_WENA];
        assign entry_waddr[i] = mem[i][OFF_WADDR +: REG_AW];
    end

endmodule

// File: rtl/commit_buffer.sv
// Commit stage: DEPTH-entry in-order queue between the memory stage and the
// GPR / CSR write ports, with a pending-write scoreboard for decode and a
// retired-instruction counter.
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   valid_pre_i / ready_pre_o    upstream entry handshake
//   pc_i, inst_i, wsel_i, wena_i, waddr_i, alu_result_i, mem_result_i,
//   csr_wena_i, csr_waddr_i, csr_wdata_i   entry payload
//   wb_ready_i                   writeback accepts a retire this cycle
//   flush_i                      discard all queued entries
//   rs1_i/rs2_i -> rs1_pending_o/rs2_pending_o   decode hazard lookup
//   commit_* , wena_o, waddr_o, wdata_o, csr_*_o  head entry / retire strobes
//   instret_o                    retired instruction count (64-bit, wraps)
//   count_o                      occupancy
// Handshake: an entry transfers on a rising edge where valid_pre_i and
// ready_pre_o are both high; ready_pre_o depends only on occupancy and
// flush_i, never on valid_pre_i, and a full buffer does not accept even when
// the head retires in the same cycle.
module commit_buffer
    import commit_buffer_pkg::*;
#(
    parameter  int DEPTH  = CB_DEPTH,
    parameter  int XLEN   = CB_XLEN,
    parameter  int REG_AW = CB_REG_AW,
    localparam int CW     = ptr_w(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_pre_i,
    output logic              ready_pre_o,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   inst_i,
    input  logic              wsel_i,
    input  logic              wena_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic [XLEN-1:0]   mem_result_i,
    input  logic              csr_wena_i,
    input  logic [XLEN-1:0]   csr_waddr_i,
    input  logic [XLEN-1:0]   csr_wdata_i,
    input  logic              wb_ready_i,
    input  logic              flush_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    output logic              rs1_pending_o,
    output logic              rs2_pending_o,
    output logic              commit_valid_o,
    output logic [XLEN-1:0]   commit_pc_o,
    output logic [XLEN-1:0]   commit_inst_o,
    output logic              wena_o,
    output logic [REG_AW-1:0] waddr_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              csr_wena_o,
    output logic [XLEN-1:0]   csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic [63:0]       instret_o,
    output logic [CW-1:0]     count_o
);

    localparam int EW = entry_w(XLEN, REG_AW);

    logic [EW-1:0]                push_entry;
    logic [EW-1:0]                head_entry;
    logic [CW-1:0]                count;
    logic [DEPTH-1:0]             entry_valid;
    logic [DEPTH-1:0]             entry_wena;
    logic [DEPTH-1:0][REG_AW-1:0] entry_waddr;
    logic [XLEN-1:0]              wdata_sel;
    logic                         push;
    logic                         retire;
    logic                         head_wena;
    logic                         head_csr_wena;
    logic                         rs1_hit;
    logic                         rs2_hit;

    // Write data is resolved once, at enqueue, so the queue stores one value.
    assign wdata_sel  = wsel_i ? mem_result_i : alu_result_i;
    assign push_entry = {pc_i, inst_i, wena_i, waddr_i, wdata_sel,
                         csr_wena_i, csr_waddr_i, csr_wdata_i};

    assign ready_pre_o = (count != CW'(DEPTH)) && !flush_i;
    assign push        = valid_pre_i && ready_pre_o;
    assign retire      = (count != '0) && wb_ready_i && !flush_i;

    commit_buffer_fifo #(
        .DEPTH  (DEPTH),
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .pop         (retire),
        .flush       (flush_i),
        .push_entry  (push_entry),
        .head_entry  (head_entry),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_wena  (entry_wena),
        .entry_waddr (entry_waddr)
    );

    // head_entry is already zero while empty, so the data outputs follow it.
    assign commit_pc_o   = head_entry[off_pc(XLEN, REG_AW) +: XLEN];
    assign commit_inst_o = head_entry[off_inst(XLEN, REG_AW) +: XLEN];
    assign head_wena     = head_entry[off_wena(XLEN, REG_AW)];
    assign waddr_o       = head_entry[off_waddr(XLEN) +: REG_AW];
    assign wdata_o       = head_entry[off_wdata(XLEN) +: XLEN];
    assign head_csr_wena = head_entry[off_csr_wena(XLEN)];
    assign csr_waddr_o   = head_entry[off_csr_waddr(XLEN) +: XLEN];
    assign csr_wdata_o   = head_entry[off_csr_wdata(XLEN) +: XLEN];

    assign commit_valid_o = retire;
    // x0 writes retire normally but never strobe the register file.
    assign wena_o         = retire && head_wena && (waddr_o != '0);
    assign csr_wena_o     = retire && head_csr_wena;
    assign count_o        = count;

    // The retiring head is still valid this cycle, so it still reports pending.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && entry_wena[i] && (entry_waddr[i] == rs1_i)) begin
                rs1_hit = 1'b1;
            end
            if (entry_valid[i] && entry_wena[i] && (entry_waddr[i] == rs2_i)) begin
                rs2_hit = 1'b1;
            end
        end
    end

    assign rs1_pending_o = rs1_hit && (rs1_i != '0);
    assign rs2_pending_o = rs2_hit && (rs2_i != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instret_o <= '0;
        end else if (retire) begin
            instret_o <= instret_o + 64'd1;
        end
    end

endmodule

// File: tb/tb_commit_buffer.sv
module tb_commit_buffer;

    localparam int DEPTH  = 4;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clock;
    logic              reset;
    logic              valid_pre_i;
    logic              ready_pre_o;
    logic [XLEN-1:0]   pc_i;
    logic [XLEN-1:0]   inst_i;
    logic              wsel_i;
    logic              wena_i;
    logic [REG_AW-1:0] waddr_i;
    logic [XLEN-1:0]   alu_result_i;
    logic [XLEN-1:0]   mem_result_i;
    logic              csr_wena_i;
    logic [XLEN-1:0]   csr_waddr_i;
    logic [XLEN-1:0]   csr_wdata_i;
    logic              wb_ready_i;
    logic              flush_i;
    logic [REG_AW-1:0] rs1_i;
    logic [REG_AW-1:0] rs2_i;
    logic              rs1_pending_o;
    logic              rs2_pending_o;
    logic              commit_valid_o;
    logic [XLEN-1:0]   commit_pc_o;
    logic [XLEN-1:0]   commit_inst_o;
    logic              wena_o;
    logic [REG_AW-1:0] waddr_o;
    logic [XLEN-1:0]   wdata_o;
    logic              csr_wena_o;
    logic [XLEN-1:0]   csr_waddr_o;
    logic [XLEN-1:0]   csr_wdata_o;
    logic [63:0]       instret_o;
    logic [CW-1:0]     count_o;

    commit_buffer #(
        .DEPTH  (DEPTH),
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .valid_pre_i    (valid_pre_i),
        .ready_pre_o    (ready_pre_o),
        .pc_i           (pc_i),
        .inst_i         (inst_i),
        .wsel_i         (wsel_i),
        .wena_i         (wena_i),
        .waddr_i        (waddr_i),
        .alu_result_i   (alu_result_i),
        .mem_result_i   (mem_result_i),
        .csr_wena_i     (csr_wena_i),
        .csr_waddr_i    (csr_waddr_i),
        .csr_wdata_i    (csr_wdata_i),
        .wb_ready_i     (wb_ready_i),
        .flush_i        (flush_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .rs1_pending_o  (rs1_pending_o),
        .rs2_pending_o  (rs2_pending_o),
        .commit_valid_o (commit_valid_o),
        .commit_pc_o    (commit_pc_o),
        .commit_inst_o  (commit_inst_o),
        .wena_o         (wena_o),
        .waddr_o        (waddr_o),
        .wdata_o        (wdata_o),
        .csr_wena_o     (csr_wena_o),
        .csr_waddr_o    (csr_waddr_o),
        .csr_wdata_o    (csr_wdata_o),
        .instret_o      (instret_o),
        .count_o        (count_o)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // One record per accepted instruction, in program order; wdata already
    // holds the value the instruction is meant to write.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        wena;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_wena;
        logic [31:0] csr_waddr;
        logic [31:0] csr_wdata;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    logic [63:0]      model_instret;
    int               n_checks;
    int               n_pass;
    bit               mon_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the next one.
    task automatic drive(input logic v, input exp_t f, input logic wsel,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic wbr, input logic fl, output logic acc);
        logic ready_exp;
        exp_t e;
        #1;
        valid_pre_i  = v;
        pc_i         = f.pc;
        inst_i       = f.inst;
        wena_i       = f.wena;
        waddr_i      = f.waddr;
        wsel_i       = wsel;
        alu_result_i = alu;
        mem_result_i = mem;
        csr_wena_i   = f.csr_wena;
        csr_waddr_i  = f.csr_waddr;
        csr_wdata_i  = f.csr_wdata;
        wb_ready_i   = wbr;
        flush_i      = fl;
        #3;
        ready_exp = (exp_q.size() != DEPTH) && !fl;
        chk("ready_pre", ready_pre_o, ready_exp);
        acc = v && ready_exp;
        @(posedge clock);
        if (fl) begin
            exp_q.delete();
        end else if (acc) begin
            e       = f;
            e.wdata = wsel ? mem : alu;
            exp_q.push_back(e);
        end
    endtask

    task automatic rand_step(input logic v, input logic wbr, input logic fl,
                             input logic [31:0] pc, output logic acc);
        exp_t f;
        f.pc        = pc;
        f.inst      = $urandom;
        f.wena      = 1'($urandom_range(0, 1));
        f.waddr     = 5'($urandom_range(0, 7));
        f.wdata     = '0;
        f.csr_wena  = 1'($urandom_range(0, 1));
        f.csr_waddr = $urandom;
        f.csr_wdata = $urandom;
        drive(v, f, 1'($urandom_range(0, 1)), $urandom, $urandom, wbr, fl, acc);
    endtask

    task automatic idle(input int n, input logic wbr);
        logic acc;
        for (int i = 0; i < n; i++) rand_step(1'b0, wbr, 1'b0, $urandom, acc);
    endtask

    task automatic push_reg(input logic [31:0] pc, input logic wena, input logic [4:0] waddr,
                            input logic wbr);
        exp_t f;
        logic acc;
        f           = '0;
        f.pc        = pc;
        f.inst      = 32'h0000_0013;
        f.wena      = wena;
        f.waddr     = waddr;
        drive(1'b1, f, 1'b0, pc ^ 32'h5a5a_0000, 32'hdead_beef, wbr, 1'b0, acc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        exp_t h;
        logic ret_exp;
        logic p1;
        logic p2;
        if (mon_en) begin
            chk("count", count_o, exp_q.size());
            chk("instret", instret_o, model_instret);
            ret_exp = (exp_q.size() != 0) && wb_ready_i && !flush_i;
            chk("commit_valid", commit_valid_o, ret_exp);
            p1 = 1'b0;
            p2 = 1'b0;
            foreach (exp_q[i]) begin
                h = exp_t'(exp_q[i]);
                if (h.wena && rs1_i != 0 && h.waddr == rs1_i) p1 = 1'b1;
                if (h.wena && rs2_i != 0 && h.waddr == rs2_i) p2 = 1'b1;
            end
            chk("rs1_pending", rs1_pending_o, p1);
            chk("rs2_pending", rs2_pending_o, p2);
            if (exp_q.size() != 0) begin
                h = exp_t'(exp_q[0]);
                chk("commit_pc", commit_pc_o, h.pc);
                chk("commit_inst", commit_inst_o, h.inst);
                chk("waddr", waddr_o, h.waddr);
                chk("wdata", wdata_o, h.wdata);
                chk("csr_waddr", csr_waddr_o, h.csr_waddr);
                chk("csr_wdata", csr_wdata_o, h.csr_wdata);
                chk("wena", wena_o, ret_exp && h.wena && h.waddr != 0);
                chk("csr_wena", csr_wena_o, ret_exp && h.csr_wena);
            end else begin
                chk("empty_pc", commit_pc_o, 0);
                chk("empty_wdata", wdata_o, 0);
                chk("empty_wena", wena_o, 0);
                chk("empty_csr_wena", csr_wena_o, 0);
            end
            if (ret_exp) begin
                void'(exp_q.pop_front());
                model_instret = model_instret + 64'd1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        exp_t f;
        int   sent;
        int   tries;

        n_checks      = 0;
        n_pass        = 0;
        mon_en        = 1'b0;
        model_instret = '0;
        reset         = 1'b0;
        valid_pre_i   = 1'b0;
        pc_i          = '0;
        inst_i        = '0;
        wsel_i        = 1'b0;
        wena_i        = 1'b0;
        waddr_i       = '0;
        alu_result_i  = '0;
        mem_result_i  = '0;
        csr_wena_i    = 1'b0;
        csr_waddr_i   = '0;
        csr_wdata_i   = '0;
        wb_ready_i    = 1'b0;
        flush_i       = 1'b0;
        rs1_i         = '0;
        rs2_i         = '0;

        // Reset state
        #12;
        chk("rst_count", count_o, 0);
        chk("rst_ready", ready_pre_o, 1);
        chk("rst_commit_valid", commit_valid_o, 0);
        chk("rst_instret", instret_o, 0);
        chk("rst_wena", wena_o, 0);
        chk("rst_wdata", wdata_o, 0);
        #5;
        reset = 1'b1;
        @(posedge clock);
        mon_en = 1'b1;

        // 1. single pass
        f           = '0;
        f.pc        = 32'h8000_0000;
        f.inst      = 32'h0000_0093;
        f.wena      = 1'b1;
        f.waddr     = 5'd5;
        drive(1'b1, f, 1'b0, 32'h1234, 32'hffff_ffff, 1'b1, 1'b0, acc);
        idle(2, 1'b1);

        // 2. fill while stalled, one refused push, then drain in order
        for (int i = 0; i < DEPTH; i++) push_reg(32'h100 + 32'(4 * i), 1'b1, 5'(i + 1), 1'b0);
        rand_step(1'b1, 1'b0, 1'b0, 32'h200, acc);
        idle(DEPTH + 1, 1'b1);

        // 3. stream 10 entries with wb_ready toggling; retry refused pushes
        sent = 0;
        tries = 0;
        while (sent < 10 && tries < 40) begin
            rand_step(1'b1, 1'((sent + tries) % 2 == 0), 1'b0, 32'h1000 + 32'(4 * sent), acc);
            if (acc) sent++;
            tries++;
        end
        chk("stream_sent", sent, 10);
        idle(12, 1'b1);

        // 4. flush with three entries queued (a push offered in the same cycle)
        for (int i = 0; i < 3; i++) push_reg(32'h3000 + 32'(4 * i), 1'b1, 5'd3, 1'b0);
        rand_step(1'b1, 1'b1, 1'b1, 32'h3100, acc);
        idle(2, 1'b1);

        // 5. scoreboard and x0
        rs1_i = 5'd7;
        rs2_i = 5'd0;
        push_reg(32'h4000, 1'b1, 5'd7, 1'b0);
        push_reg(32'h4004, 1'b1, 5'd0, 1'b0);
        idle(1, 1'b0);
        idle(3, 1'b1);

        // 6. asynchronous reset with two entries queued
        push_reg(32'h5000, 1'b1, 5'd7, 1'b0);
        push_reg(32'h5004, 1'b1, 5'd7, 1'b0);
        valid_pre_i = 1'b0;
        wb_ready_i  = 1'b0;
        flush_i     = 1'b0;
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("arst_count", count_o, 0);
        chk("arst_ready", ready_pre_o, 1);
        chk("arst_commit_valid", commit_valid_o, 0);
        chk("arst_instret", instret_o, 0);
        chk("arst_pc", commit_pc_o, 0);
        chk("arst_rs1_pending", rs1_pending_o, 0);
        exp_q.delete();
        model_instret = '0;
        #3;
        reset = 1'b1;
        @(posedge clock);
        mon_en = 1'b1;

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            rs1_i = 5'($urandom_range(0, 7));
            rs2_i = 5'($urandom_range(0, 7));
            rand_step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                      1'($urandom_range(0, 19) == 0), $urandom, acc);
        end
        idle(DEPTH + 4, 1'b1);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
